// File: rtl/cpu7_exu_pkg.sv
// Shared EXU definitions: default index/tag widths and long-latency unit tags.
package cpu7_exu_pkg;

  localparam int RIDX_DEF = 5;
  localparam int TAGW_DEF = 2;

  localparam logic [TAGW_DEF-1:0] TAG_LSU = 2'd0;
  localparam logic [TAGW_DEF-1:0] TAG_MUL = 2'd1;
  localparam logic [TAGW_DEF-1:0] TAG_DIV = 2'd2;
  localparam logic [TAGW_DEF-1:0] TAG_CSR = 2'd3;

endpackage

// File: rtl/cpu7_exu_scbd_entry.sv
// One scoreboard entry: pending bit plus producer tag.
// Priority is flush, then set, then clear.
module cpu7_exu_scbd_entry
  import cpu7_exu_pkg::*;
#(
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            set,
  input  logic [TAGW-1:0] set_tag,
  input  logic            clr,
  output logic            pending,
  output logic [TAGW-1:0] tag
);

  logic            pending_r;
  logic [TAGW-1:0] tag_r;

  // Pending/tag state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 1'b0;
      tag_r     <= '0;
    end else if (flush) begin
      pending_r <= 1'b0;
    end else if (set) begin
      pending_r <= 1'b1;
      tag_r     <= set_tag;
    end else if (clr) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign pending = pending_r;
  assign tag     = tag_r;

endmodule

// File: rtl/cpu7_exu_scbd.sv
// Multi-lane register scoreboard: RAW/WAW hazard detection, in-order grant,
// writeback bypass of clears and a saturating stall counter.
module cpu7_exu_scbd
  import cpu7_exu_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int WBPORTS = 2,
  parameter int NREG    = 32,
  parameter int RIDX    = RIDX_DEF,
  parameter int TAGW    = TAGW_DEF,
  parameter int CNTW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        issue_valid_d,
  input  logic [LANES*RIDX-1:0]   issue_rs1_d,
  input  logic [LANES*RIDX-1:0]   issue_rs2_d,
  input  logic [LANES*RIDX-1:0]   issue_rd_d,
  input  logic [LANES-1:0]        issue_wen_d,
  input  logic [LANES-1:0]        issue_long_d,
  input  logic [LANES*TAGW-1:0]   issue_tag_d,
  input  logic [WBPORTS-1:0]      wb_valid_w,
  input  logic [WBPORTS*RIDX-1:0] wb_rd_w,
  input  logic [WBPORTS*TAGW-1:0] wb_tag_w,
  input  logic                    flush,
  output logic [LANES-1:0]        issue_grant_d,
  output logic                    exu_ifu_stall_req,
  output logic [NREG-1:0]         pending_vec,
  output logic [RIDX:0]           pending_cnt,
  output logic [CNTW-1:0]         stall_cnt
);

  logic [NREG-1:0]            pending_s;
  logic [NREG-1:0][TAGW-1:0]  tag_s;
  logic [NREG-1:0]            wb_hit_s;
  logic [NREG-1:0]            pend_eff_s;
  logic [NREG-1:0]            set_s;
  logic [NREG-1:0][TAGW-1:0]  set_tag_s;
  logic [LANES-1:0]           hazard_s;
  logic [LANES-1:0]           grant_s;
  logic                       stall_s;
  logic [RIDX:0]              pend_cnt_s;
  logic [CNTW-1:0]            stall_cnt_r;

  assign pending_s[0] = 1'b0;
  assign tag_s[0]     = '0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_entry
      cpu7_exu_scbd_entry #(.TAGW(TAGW)) u_entry (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .set     (set_s[g]),
        .set_tag (set_tag_s[g]),
        .clr     (wb_hit_s[g]),
        .pending (pending_s[g]),
        .tag     (tag_s[g])
      );
    end
  endgenerate

  // Writeback matches (rd and tag) both clear the entry and bypass it this cycle.
  always_comb begin
    wb_hit_s = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < WBPORTS; k++) begin
        wb_hit_s[r] = wb_hit_s[r] |
                      (wb_valid_w[k] &&
                       (wb_rd_w[k*RIDX +: RIDX] == RIDX'(r)) &&
                       (wb_tag_w[k*TAGW +: TAGW] == tag_s[r]));
      end
    end
    pend_eff_s = pending_s & ~wb_hit_s;
  end

  // Per-lane hazards, then an in-order grant prefix.
  always_comb begin
    logic [RIDX-1:0] rs1_v, rs2_v, rd_v, rdj_v;
    logic            blocked_v;
    hazard_s  = '0;
    grant_s   = '0;
    blocked_v = 1'b0;
    rs1_v     = '0;
    rs2_v     = '0;
    rd_v      = '0;
    rdj_v     = '0;
    for (int i = 0; i < LANES; i++) begin
      rs1_v = issue_rs1_d[i*RIDX +: RIDX];
      rs2_v = issue_rs2_d[i*RIDX +: RIDX];
      rd_v  = issue_rd_d[i*RIDX +: RIDX];
      hazard_s[i] = pend_eff_s[rs1_v] | pend_eff_s[rs2_v] |
                    (issue_wen_d[i] & pend_eff_s[rd_v]);
      for (int j = 0; j < i; j++) begin
        rdj_v = issue_rd_d[j*RIDX +: RIDX];
        hazard_s[i] = hazard_s[i] |
                      (issue_valid_d[j] && issue_wen_d[j] && (rdj_v != '0) &&
                       ((rdj_v == rs1_v) || (rdj_v == rs2_v) || (rdj_v == rd_v)));
      end
      grant_s[i] = issue_valid_d[i] & ~hazard_s[i] & ~blocked_v & ~flush & ~reset;
      blocked_v  = blocked_v | (issue_valid_d[i] & ~grant_s[i]);
    end
    stall_s = blocked_v & ~flush;
  end

  // Granted long-latency writers mark their destination pending.
  always_comb begin
    set_s     = '0;
    set_tag_s = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (grant_s[i] && issue_wen_d[i] && issue_long_d[i] &&
            (issue_rd_d[i*RIDX +: RIDX] == RIDX'(r))) begin
          set_s[r]     = 1'b1;
          set_tag_s[r] = issue_tag_d[i*TAGW +: TAGW];
        end else begin
          set_s[r]     = set_s[r];
          set_tag_s[r] = set_tag_s[r];
        end
      end
    end
  end

  // Population count of the registered pending bits.
  always_comb begin
    pend_cnt_s = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_cnt_s = pend_cnt_s + (RIDX+1)'(pending_s[r]);
    end
  end

  // Saturating stall-cycle counter; survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNTW'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign issue_grant_d     = grant_s;
  assign exu_ifu_stall_req = stall_s;
  assign pending_vec       = pending_s;
  assign pending_cnt       = pend_cnt_s;
  assign stall_cnt         = stall_cnt_r;

endmodule

// File: tb/tb_cpu7_exu_scbd.sv
// Directed self-checking bench for cpu7_exu_scbd (2 lanes, 2 wb ports, 4-bit stall counter).
module tb_cpu7_exu_scbd;
  import cpu7_exu_pkg::*;

  localparam int LANES = 2, WBPORTS = 2, NREG = 32, RIDX = 5, TAGW = 2, CNTW = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        issue_valid_d, issue_wen_d, issue_long_d, issue_grant_d;
  logic [LANES*RIDX-1:0]   issue_rs1_d, issue_rs2_d, issue_rd_d;
  logic [LANES*TAGW-1:0]   issue_tag_d;
  logic [WBPORTS-1:0]      wb_valid_w;
  logic [WBPORTS*RIDX-1:0] wb_rd_w;
  logic [WBPORTS*TAGW-1:0] wb_tag_w;
  logic                    flush, exu_ifu_stall_req;
  logic [NREG-1:0]         pending_vec;
  logic [RIDX:0]           pending_cnt;
  logic [CNTW-1:0]         stall_cnt;

  int checks_n = 0;
  int errors_n = 0;

  cpu7_exu_scbd #(.LANES(LANES), .WBPORTS(WBPORTS), .NREG(NREG), .RIDX(RIDX),
                  .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid_d(issue_valid_d), .issue_rs1_d(issue_rs1_d), .issue_rs2_d(issue_rs2_d),
    .issue_rd_d(issue_rd_d), .issue_wen_d(issue_wen_d), .issue_long_d(issue_long_d),
    .issue_tag_d(issue_tag_d), .wb_valid_w(wb_valid_w), .wb_rd_w(wb_rd_w),
    .wb_tag_w(wb_tag_w), .flush(flush), .issue_grant_d(issue_grant_d),
    .exu_ifu_stall_req(exu_ifu_stall_req), .pending_vec(pending_vec),
    .pending_cnt(pending_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_d = '0; issue_rs1_d = '0; issue_rs2_d = '0; issue_rd_d = '0;
    issue_wen_d = '0; issue_long_d = '0; issue_tag_d = '0;
    wb_valid_w = '0; wb_rd_w = '0; wb_tag_w = '0; flush = 1'b0;
  endtask

  task automatic lane(input int i, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic wen, input logic lng,
                      input logic [1:0] tg);
    issue_valid_d[i]       = 1'b1;
    issue_rs1_d[i*RIDX +: RIDX] = rs1;
    issue_rs2_d[i*RIDX +: RIDX] = rs2;
    issue_rd_d[i*RIDX +: RIDX]  = rd;
    issue_wen_d[i]         = wen;
    issue_long_d[i]        = lng;
    issue_tag_d[i*TAGW +: TAGW] = tg;
  endtask

  task automatic wb(input int k, input logic [4:0] rd, input logic [1:0] tg);
    wb_valid_w[k]            = 1'b1;
    wb_rd_w[k*RIDX +: RIDX]  = rd;
    wb_tag_w[k*TAGW +: TAGW] = tg;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // activity, then reset with a valid lane pending
    lane(0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, TAG_MUL);
    tick();
    idle(); lane(0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, TAG_LSU);
    tick();
    idle(); lane(0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, TAG_LSU);
    reset = 1'b1;
    #1 check("grant_in_reset", 64'(issue_grant_d), 64'h0);
    tick(); tick();
    reset = 1'b0;
    idle();
    #1;
    check("rst_pending", 64'(pending_vec), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_pending_cnt", 64'(pending_cnt), 64'h0);
    check("rst_stall", 64'(exu_ifu_stall_req), 64'h0);

    // RAW stall and bypass release
    lane(0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, TAG_LSU);
    #1 check("raw_set_grant", 64'(issue_grant_d), 64'h1);
    tick();
    check("raw_pending", 64'(pending_vec), 64'h20);
    check("raw_pcnt", 64'(pending_cnt), 64'h1);
    idle(); lane(0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, TAG_LSU);
    lane(1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, TAG_LSU);
    #1 check("raw_stall_grant", 64'(issue_grant_d), 64'h0);
    check("raw_stall_req", 64'(exu_ifu_stall_req), 64'h1);
    tick();
    check("raw_stall_cnt", 64'(stall_cnt), 64'h1);
    wb(0, 5'd5, TAG_LSU);
    #1 check("bypass_grant", 64'(issue_grant_d), 64'h3);
    check("bypass_stall", 64'(exu_ifu_stall_req), 64'h0);
    tick();
    check("bypass_cleared", 64'(pending_vec), 64'h0);
    check("bypass_cnt_hold", 64'(stall_cnt), 64'h1);

    // intra-bundle RAW, WAW, and an invalid lane that must not block
    idle(); lane(0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, TAG_LSU);
    lane(1, 5'd0, 5'd3, 5'd8, 1'b1, 1'b0, TAG_LSU);
    #1 check("intra_raw_grant", 64'(issue_grant_d), 64'h1);
    check("intra_raw_stall", 64'(exu_ifu_stall_req), 64'h1);
    tick();
    lane(1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, TAG_LSU);
    #1 check("intra_waw_grant", 64'(issue_grant_d), 64'h1);
    tick();
    issue_valid_d[0] = 1'b0;
    #1 check("invalid_noblock", 64'(issue_grant_d), 64'h2);
    check("intra_stall_cnt", 64'(stall_cnt), 64'h3);
    tick();

    // stale tag ignored; same-cycle clear and set, set wins with new tag
    idle(); lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, TAG_MUL);
    tick();
    idle(); lane(0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, TAG_LSU);
    wb(0, 5'd7, TAG_LSU);
    #1 check("stale_stall_grant", 64'(issue_grant_d), 64'h0);
    tick();
    check("stale_pending", 64'(pending_vec), 64'h80);
    idle(); wb(1, 5'd7, TAG_MUL);
    lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, TAG_LSU);
    #1 check("setclr_grant", 64'(issue_grant_d), 64'h1);
    tick();
    check("setclr_pending", 64'(pending_vec), 64'h80);
    idle(); wb(0, 5'd7, TAG_MUL);
    tick();
    check("newtag_old_stale", 64'(pending_vec), 64'h80);
    idle(); wb(0, 5'd7, TAG_LSU); wb(1, 5'd7, TAG_LSU);
    tick();
    check("newtag_clear", 64'(pending_vec), 64'h0);
    check("stale_stall_cnt", 64'(stall_cnt), 64'h4);

    // flush wipes pending and blocks a same-cycle long issue
    idle(); lane(0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, TAG_LSU);
    lane(1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, TAG_MUL);
    tick();
    idle(); lane(0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, TAG_DIV);
    tick();
    check("pre_flush_vec", 64'(pending_vec), 64'h1210);
    check("pre_flush_cnt", 64'(pending_cnt), 64'h3);
    idle(); lane(0, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1, TAG_CSR);
    flush = 1'b1;
    #1 check("flush_grant", 64'(issue_grant_d), 64'h0);
    check("flush_stall", 64'(exu_ifu_stall_req), 64'h0);
    tick();
    check("flush_vec", 64'(pending_vec), 64'h0);
    check("flush_cnt", 64'(pending_cnt), 64'h0);
    check("flush_keeps_scnt", 64'(stall_cnt), 64'h4);

    // r0 never tracked nor a hazard
    idle(); lane(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, TAG_LSU);
    lane(1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, TAG_LSU);
    #1 check("r0_grant", 64'(issue_grant_d), 64'h3);
    tick();
    check("r0_pcnt", 64'(pending_cnt), 64'h0);

    // stall counter saturation
    idle(); lane(0, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, TAG_MUL);
    tick();
    idle(); lane(0, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, TAG_LSU);
    for (int n = 0; n < 11; n++) tick();
    check("sat_reach", 64'(stall_cnt), 64'hF);
    for (int n = 0; n < 3; n++) tick();
    check("sat_hold", 64'(stall_cnt), 64'hF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
